fifo36_pkt_demux: RTL and testbench

Routes packets from one 36-bit FIFO-interface stream to one of two output FIFO interfaces, deciding per packet from the first (SOF) line. It is the receive-side counterpart to the two-input packet mux: it sits after a shared ingress stream and splits traffic into per-consumer streams. Each output has a 2-entry registered buffer. Stray lines outside a packet are dropped and counted.

---
 rtl/fifo36_pkt_demux.sv | 143 ++++++++++++++
 tb/tb_fifo36_pkt_demux.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo36_pkt_demux.sv
// fifo36_pkt_demux: steers framed 36-bit lines to one of two buffered
// output ports, choosing per packet from a masked compare of the SOF line.
module fifo36_pkt_demux #(
  parameter logic [31:0] MATCH = 32'h0000_0000,
  parameter logic [31:0] MASK  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [35:0] data_i,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] data0_o,
  output logic        src0_rdy_o,
  input  logic        dst0_rdy_i,
  output logic [35:0] data1_o,
  output logic        src1_rdy_o,
  input  logic        dst1_rdy_i,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA0 = 2'd1,
    DATA1 = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        w_sof;
  logic        w_eof;
  logic        w_match;
  logic        w_xfer;
  logic        w_drop;
  logic [1:0]  w_wr;
  logic [1:0]  w_rd;
  logic [1:0]  w_full;
  logic [1:0]  w_vld;
  logic [1:0]  w_cons;
  logic [35:0] w_head [2];
  logic [15:0] r_drop;

  assign w_sof   = data_i[32];
  assign w_eof   = data_i[33];
  assign w_match = (data_i[31:0] & MASK) == (MATCH & MASK);
  assign w_xfer  = src_rdy_i & dst_rdy_o;
  assign w_cons  = {dst1_rdy_i, dst0_rdy_i};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_state <= IDLE;
    else if (clear) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (src_rdy_i && w_sof)
          w_next = w_match ? DATA1 : DATA0;
      end
      DATA0, DATA1: begin
        if (w_xfer && w_eof)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    dst_rdy_o = 1'b0;
    w_wr      = 2'b00;
    w_drop    = 1'b0;
    case (r_state)
      IDLE: begin
        // headers wait here for the route decision; strays are eaten
        dst_rdy_o = src_rdy_i & ~w_sof;
        w_drop    = src_rdy_i & ~w_sof;
      end
      DATA0: begin
        dst_rdy_o = ~w_full[0];
        w_wr[0]   = src_rdy_i & ~w_full[0];
      end
      DATA1: begin
        dst_rdy_o = ~w_full[1];
        w_wr[1]   = src_rdy_i & ~w_full[1];
      end
      default: dst_rdy_o = 1'b0;
    endcase
  end

  for (genvar p = 0; p < 2; p++) begin : g_buf
    logic [35:0] r_mem [2];
    logic        r_wp;
    logic        r_rp;
    logic [1:0]  r_cnt;

    assign w_full[p] = r_cnt == 2'd2;
    assign w_vld[p]  = r_cnt != 2'd0;
    assign w_rd[p]   = w_vld[p] & w_cons[p];
    assign w_head[p] = w_vld[p] ? r_mem[r_rp] : 36'd0;

    always_ff @(posedge clk) begin
      if (w_wr[p])
        r_mem[r_wp] <= data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wp  <= 1'b0;
        r_rp  <= 1'b0;
        r_cnt <= 2'd0;
      end else if (clear) begin
        r_wp  <= 1'b0;
        r_rp  <= 1'b0;
        r_cnt <= 2'd0;
      end else begin
        if (w_wr[p]) r_wp <= ~r_wp;
        if (w_rd[p]) r_rp <= ~r_rp;
        r_cnt <= r_cnt + {1'b0, w_wr[p]} - {1'b0, w_rd[p]};
      end
    end
  end

  assign data0_o    = w_head[0];
  assign data1_o    = w_head[1];
  assign src0_rdy_o = w_vld[0];
  assign src1_rdy_o = w_vld[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_drop <= 16'd0;
    else if (clear)
      r_drop <= 16'd0;
    else if (w_drop && r_drop != 16'hFFFF)
      r_drop <= r_drop + 16'd1;
  end

  assign drop_count = r_drop;

endmodule

// File: tb/tb_fifo36_pkt_demux.sv
// tb_fifo36_pkt_demux: randomized packet traffic against a packet-level
// routing model; checks split, order, bubbles, stalls, drops and reset.
module tb_fifo36_pkt_demux;

  localparam logic [31:0] MATCH = 32'h0000_0000;
  localparam logic [31:0] MASK  = 32'hFFFF_FFFF;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        clear      = 1'b0;
  logic [35:0] data_i     = 36'd0;
  logic        src_rdy_i  = 1'b0;
  logic        dst_rdy_o;
  logic [35:0] data0_o;
  logic        src0_rdy_o;
  logic        dst0_rdy_i = 1'b0;
  logic [35:0] data1_o;
  logic        src1_rdy_o;
  logic        dst1_rdy_i = 1'b0;
  logic [15:0] drop_count;

  int vectors     = 0;
  int miscompares = 0;

  bit rnd_rdy = 1'b0;
  bit fix0    = 1'b1;
  bit fix1    = 1'b1;

  logic [35:0] exp0 [$];
  logic [35:0] exp1 [$];
  logic [35:0] got0 [$];
  logic [35:0] got1 [$];

  always #5 clk = ~clk;

  fifo36_pkt_demux #(
    .MATCH(MATCH),
    .MASK (MASK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .data_i    (data_i),
    .src_rdy_i (src_rdy_i),
    .dst_rdy_o (dst_rdy_o),
    .data0_o   (data0_o),
    .src0_rdy_o(src0_rdy_o),
    .dst0_rdy_i(dst0_rdy_i),
    .data1_o   (data1_o),
    .src1_rdy_o(src1_rdy_o),
    .dst1_rdy_i(dst1_rdy_i),
    .drop_count(drop_count)
  );

  initial forever begin
    @(posedge clk);
    #2;
    dst0_rdy_i = rnd_rdy ? ($urandom_range(0, 3) != 0) : fix0;
    dst1_rdy_i = rnd_rdy ? ($urandom_range(0, 2) != 0) : fix1;
  end

  // output transfers happen at the posedge after this negedge
  always @(negedge clk) begin
    if (!reset && !clear) begin
      if (src0_rdy_o && dst0_rdy_i) got0.push_back(data0_o);
      if (src1_rdy_o && dst1_rdy_i) got1.push_back(data1_o);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [35:0] mk(input logic [1:0] occ,
                                     input bit eof, input bit sof,
                                     input logic [31:0] pl);
    return {occ, eof, sof, pl};
  endfunction

  function automatic bit hits(input logic [31:0] pl);
    return (pl & MASK) == (MATCH & MASK);
  endfunction

  task automatic send_line(input logic [35:0] d, output int w);
    data_i    = d;
    src_rdy_i = 1'b1;
    w         = 0;
    while (w < 100) begin
      @(negedge clk);
      w++;
      if (dst_rdy_o) break;
    end
    if (!dst_rdy_o) begin
      miscompares++;
      $display("FAIL send_line: %h never accepted", d);
    end
    @(posedge clk);
    #1;
    src_rdy_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int n,
                          output int wh);
    logic [35:0] l;
    int          w;
    bit          sof;
    wh = 0;
    for (int i = 0; i < n; i++) begin
      sof = (i == 0) || ($urandom_range(0, 7) == 0);
      l = mk(2'($urandom), i == n - 1, sof,
             (i == 0) ? hdr : $urandom);
      if (hits(hdr)) exp1.push_back(l);
      else           exp0.push_back(l);
      send_line(l, w);
      if (i == 0) wh = w;
    end
  endtask

  task automatic drain();
    rnd_rdy = 1'b0;
    fix0    = 1'b1;
    fix1    = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i > 3 && !src0_rdy_o && !src1_rdy_o) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush_q();
    exp0.delete();
    exp1.delete();
    got0.delete();
    got1.delete();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({dst_rdy_o, src0_rdy_o, src1_rdy_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset rdy: got %b want 000",
               {dst_rdy_o, src0_rdy_o, src1_rdy_o});
    end
    vectors++;
    if ({data0_o, data1_o, drop_count} !== 88'd0) begin
      miscompares++;
      $display("FAIL reset data: got %h %h %h want 0",
               data0_o, data1_o, drop_count);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int wh, lat;
    flush_q();
    rnd_rdy = 1'b0;
    fix0    = 1'b1;
    fix1    = 1'b1;
    fork
      send_pkt(32'h0, 4, wh);
      begin
        lat = 0;
        while (!src1_rdy_o && lat < 20) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    drain();
    vectors++;
    if (lat != 2) begin
      miscompares++;
      $display("FAIL single latency: got %0d want 2", lat);
    end
    vectors++;
    if (wh != 2) begin
      miscompares++;
      $display("FAIL single bubble: got %0d want 2", wh);
    end
    vectors++;
    if (got1.size() != 4 || got0.size() != 0) begin
      miscompares++;
      $display("FAIL single counts: got %0d/%0d want 0/4",
               got0.size(), got1.size());
    end
    foreach (exp1[i]) begin
      vectors++;
      if (got1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL single p1[%0d]: got %h want %h",
                 i, got1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_one_line();
    int wh;
    logic [31:0] hdrs [3];
    hdrs[0] = 32'h1;
    hdrs[1] = 32'h0;
    hdrs[2] = 32'h1;
    flush_q();
    for (int k = 0; k < 3; k++) begin
      send_pkt(hdrs[k], 1, wh);
      vectors++;
      if (wh != 2) begin
        miscompares++;
        $display("FAIL one_line bubble %0d: got %0d want 2", k, wh);
      end
    end
    drain();
    vectors++;
    if (got0.size() != 2 || got1.size() != 1) begin
      miscompares++;
      $display("FAIL one_line counts: got %0d/%0d want 2/1",
               got0.size(), got1.size());
    end
    foreach (exp0[i]) begin
      vectors++;
      if (got0[i] !== exp0[i]) begin
        miscompares++;
        $display("FAIL one_line p0[%0d]: got %h want %h",
                 i, got0[i], exp0[i]);
      end
    end
    vectors++;
    if (got1[0] !== exp1[0]) begin
      miscompares++;
      $display("FAIL one_line p1: got %h want %h", got1[0], exp1[0]);
    end
  endtask

  task automatic test_alternating();
    int wh;
    flush_q();
    rnd_rdy = 1'b1;
    for (int k = 0; k < 8; k++)
      send_pkt((k % 2 == 0) ? 32'h1 : 32'h0, 3, wh);
    drain();
    vectors++;
    if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
      miscompares++;
      $display("FAIL alt counts: got %0d/%0d want %0d/%0d",
               got0.size(), got1.size(), exp0.size(), exp1.size());
    end
    foreach (exp0[i]) begin
      vectors++;
      if (got0[i] !== exp0[i]) begin
        miscompares++;
        $display("FAIL alt p0[%0d]: got %h want %h", i, got0[i], exp0[i]);
      end
    end
    foreach (exp1[i]) begin
      vectors++;
      if (got1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL alt p1[%0d]: got %h want %h", i, got1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_stall();
    int wh, wh2, acc, first, last;
    flush_q();
    rnd_rdy = 1'b0;
    fix0    = 1'b0;
    fix1    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_pkt(32'h1, 1, wh);
    fork
      send_pkt(32'h0, 10, wh2);
      begin
        acc = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (c == 5) fix0 = 1'b1;
          if (src_rdy_i && dst_rdy_o) acc++;
        end
        vectors++;
        if (acc != 2 || dst_rdy_o !== 1'b0) begin
          miscompares++;
          $display("FAIL stall accept: got %0d rdy %b want 2 rdy 0",
                   acc, dst_rdy_o);
        end
        vectors++;
        if (got0.size() != 1) begin
          miscompares++;
          $display("FAIL stall p0 drain: got %0d want 1", got0.size());
        end
        fix1  = 1'b1;
        acc   = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 40 && acc < 8; c++) begin
          @(negedge clk);
          if (src_rdy_i && dst_rdy_o) begin
            if (first < 0) first = c;
            last = c;
            acc++;
          end
        end
        vectors++;
        if (acc != 8 || last - first != 7) begin
          miscompares++;
          $display("FAIL stall rate: got %0d in %0d want 8 in 8",
                   acc, last - first + 1);
        end
      end
    join
    drain();
    vectors++;
    if (got0.size() != 1 || got1.size() != 10) begin
      miscompares++;
      $display("FAIL stall counts: got %0d/%0d want 1/10",
               got0.size(), got1.size());
    end
    foreach (exp1[i]) begin
      vectors++;
      if (got1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL stall p1[%0d]: got %h want %h",
                 i, got1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_stray();
    int w, wh;
    flush_q();
    pulse_clear();
    vectors++;
    if (drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL stray clear: got %0d want 0", drop_count);
    end
    for (int k = 0; k < 3; k++) begin
      send_line(mk(2'($urandom), k == 1, 1'b0, $urandom), w);
      vectors++;
      if (w != 1) begin
        miscompares++;
        $display("FAIL stray take %0d: got %0d want 1", k, w);
      end
    end
    send_pkt($urandom_range(0, 1) ? 32'h0 : 32'h5, 4, wh);
    drain();
    vectors++;
    if (drop_count !== 16'd3) begin
      miscompares++;
      $display("FAIL stray count: got %0d want 3", drop_count);
    end
    vectors++;
    if (got0.size() + got1.size() != 4) begin
      miscompares++;
      $display("FAIL stray lines: got %0d want 4",
               got0.size() + got1.size());
    end
    foreach (exp0[i]) begin
      vectors++;
      if (got0[i] !== exp0[i]) begin
        miscompares++;
        $display("FAIL stray p0[%0d]: got %h want %h",
                 i, got0[i], exp0[i]);
      end
    end
    foreach (exp1[i]) begin
      vectors++;
      if (got1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL stray p1[%0d]: got %h want %h",
                 i, got1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_random();
    int w, wh, ns, drops;
    logic [31:0] hdr;
    flush_q();
    pulse_clear();
    rnd_rdy = 1'b1;
    drops   = 0;
    for (int k = 0; k < 12; k++) begin
      ns = $urandom_range(0, 2);
      for (int s = 0; s < ns; s++)
        send_line(mk(2'($urandom), 1'($urandom), 1'b0, $urandom), w);
      drops += ns;
      hdr = $urandom_range(0, 1) ? 32'h0 : ($urandom | 32'h1);
      send_pkt(hdr, $urandom_range(1, 6), wh);
    end
    drain();
    vectors++;
    if (drop_count !== 16'(drops)) begin
      miscompares++;
      $display("FAIL random drops: got %0d want %0d", drop_count, drops);
    end
    vectors++;
    if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
      miscompares++;
      $display("FAIL random counts: got %0d/%0d want %0d/%0d",
               got0.size(), got1.size(), exp0.size(), exp1.size());
    end
    foreach (exp0[i]) begin
      vectors++;
      if (got0[i] !== exp0[i]) begin
        miscompares++;
        $display("FAIL random p0[%0d]: got %h want %h",
                 i, got0[i], exp0[i]);
      end
    end
    foreach (exp1[i]) begin
      vectors++;
      if (got1[i] !== exp1[i]) begin
        miscompares++;
        $display("FAIL random p1[%0d]: got %h want %h",
                 i, got1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_trunc(input bit use_clear);
    logic [35:0] l [5];
    int          w;
    flush_q();
    rnd_rdy = 1'b0;
    fix0    = 1'b1;
    fix1    = 1'b1;
    for (int i = 0; i < 5; i++)
      l[i] = mk(2'($urandom), i == 4, i == 0,
                (i == 0) ? 32'h0 : $urandom);
    send_line(l[0], w);
    send_line(l[1], w);
    if (use_clear) begin
      clear = 1'b1;
      #1;
      vectors++;
      if (src1_rdy_o !== 1'b1) begin
        miscompares++;
        $display("FAIL clear early: src1_rdy got %b want 1", src1_rdy_o);
      end
      @(posedge clk);
      #1;
      clear = 1'b0;
    end else begin
      #2;
      reset = 1'b1;
      #1;
    end
    vectors++;
    if ({dst_rdy_o, src0_rdy_o, src1_rdy_o, data0_o, data1_o,
         drop_count} !== 91'd0) begin
      miscompares++;
      $display("FAIL trunc%0d zero: rdy %b%b%b d %h %h cnt %0d want 0",
               use_clear, dst_rdy_o, src0_rdy_o, src1_rdy_o,
               data0_o, data1_o, drop_count);
    end
    if (!use_clear) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
    got0.delete();
    got1.delete();
    for (int i = 2; i < 5; i++) begin
      send_line(l[i], w);
      vectors++;
      if (w != 1) begin
        miscompares++;
        $display("FAIL trunc%0d take %0d: got %0d want 1",
                 use_clear, i, w);
      end
    end
    drain();
    vectors++;
    if (drop_count !== 16'd3 || got0.size() != 0 || got1.size() != 0) begin
      miscompares++;
      $display("FAIL trunc%0d after: drops %0d out %0d/%0d want 3 0/0",
               use_clear, drop_count, got0.size(), got1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_one_line();
    test_alternating();
    test_stall();
    test_stray();
    test_random();
    test_trunc(1'b0);
    test_trunc(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
